// File: rtl/rv_pkg.sv
// Shared core definitions: supported opcodes and the loader state encoding.
package rv_pkg;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
  } ld_state_t;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction
endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte packer: collects bytes 0..2 in lanes, byte 3 completes the word.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_rdy
);
  logic [1:0]  cnt;
  logic [23:0] lanes;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt   <= 2'd0;
      lanes <= 24'd0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    lanes[7:0]   <= data;
        2'd1:    lanes[15:8]  <= data;
        2'd2:    lanes[23:16] <= data;
        default: ;
      endcase
    end
  end

  // Byte 3 is taken straight from the input so the word is ready on its own transfer edge.
  assign word     = {data, lanes};
  assign word_rdy = en && (cnt == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: length header, word packing, one write per word, opcode screening.
module imem_loader
  import rv_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              bad_op,
  output logic [ADDR_W-1:0] bad_op_addr
);
  ld_state_t       state;
  logic [15:0]     len;
  logic [ADDR_W:0] widx;
  logic [15:0]     hdr_len, widx_nxt;
  logic            xfer, pack_en, start_ok, word_rdy;
  logic [31:0]     word;

  assign in_ready  = busy;
  assign core_hold = busy;
  assign xfer      = in_valid && busy;
  assign pack_en   = xfer && (state == S_DATA);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign hdr_len   = {in_data, len[7:0]};
  assign widx_nxt  = 16'(widx) + 16'd1;

  word_packer u_pack (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok),
    .en       (pack_en),
    .data     (in_data),
    .word     (word),
    .word_rdy (word_rdy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_len     <= 1'b0;
      bad_op      <= 1'b0;
      bad_op_addr <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      len         <= 16'd0;
      widx        <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          state       <= S_LEN_LO;
          busy        <= 1'b1;
          done        <= 1'b0;
          err_len     <= 1'b0;
          bad_op      <= 1'b0;
          bad_op_addr <= '0;
          widx        <= '0;
        end
        S_LEN_LO: if (xfer) begin
          len[7:0] <= in_data;
          state    <= S_LEN_HI;
        end
        S_LEN_HI: if (xfer) begin
          len[15:8] <= in_data;
          if (hdr_len == 16'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (hdr_len > 16'(DEPTH)) begin
            state   <= S_ERR;
            busy    <= 1'b0;
            err_len <= 1'b1;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (word_rdy) begin
          imem_we    <= 1'b1;
          imem_addr  <= widx[ADDR_W-1:0];
          imem_wdata <= word;
          widx       <= widx_nxt[ADDR_W:0];
          // Only the first offender is recorded; the word is written regardless.
          if (!op_legal(word[6:0]) && !bad_op) begin
            bad_op      <= 1'b1;
            bad_op_addr <= widx[ADDR_W-1:0];
          end
          if (widx_nxt == len) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised loader bench: a queue of expected writes per load plus first-bad-opcode tracking.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, core_hold, busy, done, err_len, bad_op;
  logic [AW-1:0] imem_addr, bad_op_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err_len(err_len),
    .bad_op(bad_op), .bad_op_addr(bad_op_addr)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_fail = 0, n_xfer = 0;
  logic [31:0]   wbuf [0:DEPTH-1];
  logic [AW-1:0] q_addr [$];
  logic [31:0]   q_data [$];
  logic          model_bad = 1'b0;
  logic [AW-1:0] model_bad_addr = '0;
  logic [6:0]    ops [4] = '{7'h33, 7'h03, 7'h23, 7'h63};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] w);
    for (int i = 0; i < 4; i++) if (w[6:0] == ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {25'd0, in_ready, imem_we, core_hold, busy, done, err_len, bad_op}, 32'd0);
    chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_badaddr"}, {24'd0, bad_op_addr}, 32'd0);
  endtask

  // Every-cycle compare against the expected write stream.
  initial begin
    logic [AW-1:0] a;
    logic [31:0]   d;
    forever begin
      @(posedge clk); #1;
      chk("hold_eq_busy", {31'd0, core_hold}, {31'd0, busy});
      chk("ready_eq_busy", {31'd0, in_ready}, {31'd0, busy});
      if (imem_we) begin
        if (q_addr.size() == 0) chk("unexpected_write", {31'd0, imem_we}, 32'd0);
        else begin
          a = q_addr.pop_front();
          d = q_data.pop_front();
          chk("waddr", {24'd0, imem_addr}, {24'd0, a});
          chk("wdata", imem_wdata, d);
          if (!legal(d) && !model_bad) begin
            model_bad      = 1'b1;
            model_bad_addr = a;
          end
          if (q_addr.size() == 0) begin
            chk("done_with_last", {31'd0, done}, 32'd1);
            chk("busy_low_last", {31'd0, busy}, 32'd0);
          end
        end
      end
      chk("bad_op", {31'd0, bad_op}, {31'd0, model_bad});
      chk("bad_op_addr", {24'd0, bad_op_addr}, {24'd0, model_bad_addr});
    end
  end

  task automatic run_load(input int len, input int gap_pct, input int abort_words, input bit mid_start);
    int total, idx, cyc;
    bit ok_len, xf;
    logic [15:0] l16;
    l16    = 16'(len);
    ok_len = (len > 0) && (len <= DEPTH);
    @(negedge clk);
    start          = 1'b1;
    model_bad      = 1'b0;
    model_bad_addr = '0;
    if (ok_len) for (int i = 0; i < len; i++) begin
      q_addr.push_back(AW'(i));
      q_data.push_back(wbuf[i]);
    end
    total  = ok_len ? 2 + 4 * len : 2;
    n_xfer = 0; idx = 0; cyc = 0;
    @(negedge clk);
    start = 1'b0;
    while (idx < total && cyc < 20000) begin
      if (idx == 0)      in_data = l16[7:0];
      else if (idx == 1) in_data = l16[15:8];
      else               in_data = wbuf[(idx-2)/4][8*((idx-2)%4) +: 8];
      in_valid = ($urandom_range(99) >= gap_pct);
      start    = mid_start && (idx == 7);
      xf       = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (xf) begin
        idx++;
        n_xfer++;
        if (idx == 2) begin
          if (len == 0) begin
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_hold", {31'd0, core_hold}, 32'd0);
          end else if (len > DEPTH) begin
            chk("errlen_set", {31'd0, err_len}, 32'd1);
            chk("errlen_busy", {31'd0, busy}, 32'd0);
            chk("errlen_ready", {31'd0, in_ready}, 32'd0);
            chk("errlen_done", {31'd0, done}, 32'd0);
          end else chk("hdr_busy", {31'd0, busy}, 32'd1);
        end
        if (abort_words > 0 && idx == 2 + 4 * abort_words) begin
          in_valid = 1'b0;
          start    = 1'b0;
          reset    = 1'b1;
          q_addr.delete();
          q_data.delete();
          model_bad      = 1'b0;
          model_bad_addr = '0;
          @(negedge clk);
          check_zero("abort_reset");
          reset = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (cyc >= 20000) chk("stream_timeout", idx, total);
    cyc = 0;
    while (!(done || err_len) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("load_finished", {31'd0, done || err_len}, 32'd1);
    chk("xfer_count", n_xfer, total);
    chk("queue_drained", q_addr.size(), 0);
    chk("done_final", {31'd0, done}, {31'd0, len <= DEPTH});
    chk("err_final", {31'd0, err_len}, {31'd0, len > DEPTH});
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      wbuf[i] = $urandom;
      if ($urandom_range(3) != 0) wbuf[i][6:0] = ops[$urandom_range(3)];
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    wbuf[0] = 32'h00B50533; wbuf[1] = 32'h0000A083;
    run_load(2, 0, 0, 0);
    chk("t1_xfers", n_xfer, 10);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_bad", {31'd0, bad_op}, 32'd0);

    run_load(0, 0, 0, 0);
    run_load(257, 0, 0, 0);
    chk("t3_ready", {31'd0, in_ready}, 32'd0);

    wbuf[0] = 32'h00000033; wbuf[1] = 32'h00000013; wbuf[2] = 32'h0000006F;
    run_load(3, 0, 0, 0);
    chk("t4_bad", {31'd0, bad_op}, 32'd1);
    chk("t4_badaddr", {24'd0, bad_op_addr}, 32'd1);

    fill_random(4);
    run_load(4, 40, 1, 0);
    wbuf[0] = 32'h00208023;
    run_load(1, 30, 0, 0);
    chk("t5_done", {31'd0, done}, 32'd1);

    fill_random(5);
    run_load(5, 20, 0, 1);

    repeat (8) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run_load(n, $urandom_range(0, 50), 0, 0);
    end

    fill_random(DEPTH);
    run_load(DEPTH, 10, 0, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
